// File: rtl/sram_uart_dump_pkg.sv
// Shared types for the SRAM-to-UART dump block.
// Holds the dump FSM and serializer state encodings.
package sram_uart_dump_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_LATCH,
    S_TX_HI,
    S_TX_LO,
    S_FINISH
  } dump_state_type;

  typedef enum logic [1:0] {
    S_TXI_IDLE,
    S_TXI_START,
    S_TXI_DATA,
    S_TXI_STOP
  } txi_state_type;

endpackage

// File: rtl/sram_uart_dump_tx.sv
// 8N1 byte serializer, LSB first, line idle high.
// Ready also rises in the last stop-bit cycle so frames can abut.
module uart_tx_byte
  import sram_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       Ready,
  output logic       Tx
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  txi_state_type st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          last;

  assign last  = (cnt_q == LAST);
  assign Ready = (st_q == S_TXI_IDLE) ||
                 ((st_q == S_TXI_STOP) && last);
  assign Tx    = tx_q;

  // Bit timing, shifting and line drive; reset forces the line idle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      st_q  <= S_TXI_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q  <= '0;
      tx_q  <= 1'b1;
    end else if (Load && Ready) begin
      st_q  <= S_TXI_START;
      cnt_q <= '0;
      sh_q  <= Data;
      tx_q  <= 1'b0;
    end else begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      unique case (st_q)
        S_TXI_IDLE: cnt_q <= '0;
        S_TXI_START: begin
          if (last) begin
            st_q  <= S_TXI_DATA;
            idx_q <= '0;
            tx_q  <= sh_q[0];
          end
        end
        S_TXI_DATA: begin
          if (last) begin
            if (idx_q == 3'd7) begin
              st_q <= S_TXI_STOP;
              tx_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              sh_q  <= {1'b0, sh_q[7:1]};
              tx_q  <= sh_q[1];
            end
          end
        end
        S_TXI_STOP: begin
          if (last) st_q <= S_TXI_IDLE;
        end
        default: st_q <= S_TXI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_uart_dump.sv
// Streams a block of SRAM words out of the UART, high byte first.
// The next word is prefetched while the low byte is on the line.
module sram_uart_dump
  import sram_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done,
  output logic        UART_TX_O
);

  dump_state_type state_q;
  logic [17:0] addr_q;
  logic [17:0] rem_q;
  logic [15:0] buf_q;
  logic [15:0] next_q;
  logic [2:0]  pf_q;
  logic        fin_q;
  logic        busy_q;
  logic        done_q;
  logic        tx_ready;
  logic        tx_load;
  logic [7:0]  tx_data;

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_q;
  assign Done         = done_q;

  assign tx_load = tx_ready &&
                   ((state_q == S_TX_HI) ||
                    (state_q == S_TX_LO));
  assign tx_data = (state_q == S_TX_HI) ?
                   next_q[15:8] : buf_q[7:0];

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .Clock (Clock),
    .Resetn(Resetn),
    .Load  (tx_load),
    .Data  (tx_data),
    .Ready (tx_ready),
    .Tx    (UART_TX_O)
  );

  // Dump sequencing, counters, word buffers and prefetch pipeline.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      next_q  <= '0;
      pf_q    <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pf_q   <= {pf_q[1:0], 1'b0};
      if (pf_q[2]) next_q <= SRAM_read_data;
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            busy_q <= 1'b1;
            rem_q  <= Word_count;
            if (Word_count == '0) begin
              state_q <= S_FINISH;
            end else begin
              addr_q  <= Base_address;
              state_q <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: state_q <= S_RD_WAIT;
        S_RD_WAIT: state_q <= S_RD_LATCH;
        S_RD_LATCH: begin
          buf_q   <= SRAM_read_data;
          next_q  <= SRAM_read_data;
          state_q <= S_TX_HI;
        end
        S_TX_HI: begin
          if (tx_ready) begin
            buf_q   <= next_q;
            state_q <= S_TX_LO;
          end
        end
        S_TX_LO: begin
          if (tx_ready) begin
            rem_q  <= rem_q - 18'd1;
            addr_q <= addr_q + 18'd1;
            if (rem_q == 18'd1) begin
              state_q <= S_FINISH;
            end else begin
              pf_q    <= 3'b001;
              state_q <= S_TX_HI;
            end
          end
        end
        S_FINISH: begin
          if (fin_q) begin
            fin_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (tx_ready) begin
            fin_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
